// File: rtl/neural_pkg.sv
// Shared Q16.16 fixed-point types, limits and MAC state encoding.
// Saturating arithmetic is used when NEURON_MAC_SAT_EN is defined.
package neural_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned FRAC_BITS = 16;

  typedef logic signed [DATA_W-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  // Signed add clamped to the Q16.16 range
  function automatic fixed_t sat_add(input fixed_t a, input fixed_t b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? FIXED_MIN : FIXED_MAX;
    end
    return fixed_t'(s[DATA_W-1:0]);
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Combinational Q16.16 multiply: full signed product, bits [47:16] kept
// (floor truncation). Clamps instead of wrapping when NEURON_MAC_SAT_EN
// is defined.
module fixed_mul
  import neural_pkg::*;
(
  input  fixed_t i_a,
  input  fixed_t i_b,
  output fixed_t o_prod_c
);

  logic signed [PROD_W-1:0] w_full;
  logic                     w_unused;

  assign w_full   = PROD_W'(i_a) * PROD_W'(i_b);
  // Fraction bits below the result and sign-extension bits are dropped
  assign w_unused = ^{w_full[PROD_W-1:FRAC_BITS+DATA_W], w_full[FRAC_BITS-1:0]};

`ifdef NEURON_MAC_SAT_EN
  logic [PROD_W-FRAC_BITS-DATA_W:0] w_upper;
  logic                             w_ovf;

  // Result fits only if bits [63:47] are all copies of the sign
  assign w_upper = w_full[PROD_W-1:FRAC_BITS+DATA_W-1];
  assign w_ovf   = !((&w_upper) || (~|w_upper));

  // Clamp an out-of-range product to the representable extreme
  always_comb begin
    o_prod_c = fixed_t'(w_full[FRAC_BITS+DATA_W-1:FRAC_BITS]);
    if (w_ovf) begin
      o_prod_c = w_full[PROD_W-1] ? FIXED_MIN : FIXED_MAX;
    end
  end
`else
  assign o_prod_c = fixed_t'(w_full[FRAC_BITS+DATA_W-1:FRAC_BITS]);
`endif

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sums in_data*in_weight over a vector of beats
// on top of a preloaded bias, then presents the sum until downstream takes
// it. Optional macro NEURON_MAC_SAT_EN selects saturating instead of
// wrap-around product and accumulate arithmetic.
module neuron_mac
  import neural_pkg::*;
#(
  parameter int unsigned MAX_INPUTS = 16,
  parameter fixed_t      BIAS       = 32'sh0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned CNT_W = $clog2(MAX_INPUTS + 1);

  mac_state_t       r_state;
  fixed_t           r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  fixed_t           r_out_data;

  fixed_t           w_prod;
  fixed_t           w_base;
  fixed_t           w_sum;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_accept;
  logic             w_last;

  fixed_mul u_fixed_mul (
    .i_a      (fixed_t'(in_data)),
    .i_b      (fixed_t'(in_weight)),
    .o_prod_c (w_prod)
  );

  assign w_accept    = in_valid && r_in_ready;
  // First beat of a vector starts from the bias, later beats from the sum
  assign w_base      = (r_state == IDLE) ? BIAS : r_acc;
  assign w_count_nxt = (r_state == IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_last      = in_last || (w_count_nxt == CNT_W'(MAX_INPUTS));

`ifdef NEURON_MAC_SAT_EN
  assign w_sum = sat_add(w_base, w_prod);
`else
  assign w_sum = w_base + w_prod;
`endif

  // Vector sequencing, accumulation and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            if (w_last) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_sum;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
